// File: rtl/reservation_station.sv
`default_nettype none
// ============================================================================
// Module   : reservation_station
// Summary  : ALU reservation station. Holds renamed ALU/branch instructions
//            until both operands are resolved, snoops the ALU and LSB result
//            buses for wakeup, and dispatches one ready entry per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module reservation_station #(
    parameter int RS_SIZE   = 8,
    parameter int ROB_WIDTH = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear,

    input  logic                 issue_valid,
    input  logic [2:0]           issue_type,
    input  logic [7:0]           issue_op,
    input  logic [31:0]          issue_val_j,
    input  logic [31:0]          issue_val_k,
    input  logic                 issue_has_dep_j,
    input  logic                 issue_has_dep_k,
    input  logic [ROB_WIDTH-1:0] issue_dep_j,
    input  logic [ROB_WIDTH-1:0] issue_dep_k,
    input  logic [ROB_WIDTH-1:0] issue_rob_id,
    output logic                 rs_full,

    input  logic                 alu_cdb_valid,
    input  logic [ROB_WIDTH-1:0] alu_cdb_rob_id,
    input  logic [31:0]          alu_cdb_val,
    input  logic                 lsb_cdb_valid,
    input  logic [ROB_WIDTH-1:0] lsb_cdb_rob_id,
    input  logic [31:0]          lsb_cdb_val,

    output logic                 alu_en,
    output logic [2:0]           alu_type,
    output logic [7:0]           alu_op,
    output logic [31:0]          alu_val_j,
    output logic [31:0]          alu_val_k,
    output logic [ROB_WIDTH-1:0] alu_rob_id
);

    localparam int c_IDX_W = $clog2(RS_SIZE);
    localparam int c_CNT_W = $clog2(RS_SIZE) + 1;
    // Occupancy at which the decoder is told to stop; one slot of margin
    // covers the decoder's one-cycle issue latency.
    localparam logic [c_CNT_W-1:0] c_FULL_MARK = c_CNT_W'(RS_SIZE - 1);

    // ------------------------------------------------------------------
    // Entry storage
    // ------------------------------------------------------------------
    logic [RS_SIZE-1:0]   r_busy;
    logic [RS_SIZE-1:0]   r_has_dep_j;
    logic [RS_SIZE-1:0]   r_has_dep_k;
    logic [2:0]           r_type   [RS_SIZE];
    logic [7:0]           r_op     [RS_SIZE];
    logic [31:0]          r_val_j  [RS_SIZE];
    logic [31:0]          r_val_k  [RS_SIZE];
    logic [ROB_WIDTH-1:0] r_dep_j  [RS_SIZE];
    logic [ROB_WIDTH-1:0] r_dep_k  [RS_SIZE];
    logic [ROB_WIDTH-1:0] r_rob_id [RS_SIZE];
    logic [c_CNT_W-1:0]   r_count;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [RS_SIZE-1:0] w_ready;
    logic               w_free_found;
    logic [c_IDX_W-1:0] w_free_idx;
    logic               w_rdy_found;
    logic [c_IDX_W-1:0] w_rdy_idx;
    logic               w_issue_acc;
    logic [c_CNT_W-1:0] w_count_next;
    // Snoop results are {hit, value}.
    logic [32:0]        w_snp_j [RS_SIZE];
    logic [32:0]        w_snp_k [RS_SIZE];
    logic [32:0]        w_iss_snp_j;
    logic [32:0]        w_iss_snp_k;

    // Look up a tag on both result buses; the ALU bus wins on a tag tie.
    function automatic logic [32:0] f_snoop(input logic [ROB_WIDTH-1:0] tag);
        if (alu_cdb_valid && (alu_cdb_rob_id == tag)) begin
            return {1'b1, alu_cdb_val};
        end else if (lsb_cdb_valid && (lsb_cdb_rob_id == tag)) begin
            return {1'b1, lsb_cdb_val};
        end
        return {1'b0, 32'h0};
    endfunction

    // Readiness uses registered state only, so a same-cycle wakeup cannot
    // dispatch until the following cycle.
    for (genvar gi = 0; gi < RS_SIZE; gi++) begin : g_ready
        assign w_ready[gi] = r_busy[gi] & ~r_has_dep_j[gi] & ~r_has_dep_k[gi];
    end

    // Lowest-index free slot and lowest-index ready slot (pre-edge state).
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        w_rdy_found  = 1'b0;
        w_rdy_idx    = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = c_IDX_W'(i);
            end
            if (w_ready[i]) begin
                w_rdy_found = 1'b1;
                w_rdy_idx   = c_IDX_W'(i);
            end
        end
    end

    // Broadcast snoop for every stored operand and for the issuing operands.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            w_snp_j[i] = f_snoop(r_dep_j[i]);
            w_snp_k[i] = f_snoop(r_dep_k[i]);
        end
        w_iss_snp_j = f_snoop(issue_dep_j);
        w_iss_snp_k = f_snoop(issue_dep_k);
    end

    // Issue acceptance and next occupancy.
    always_comb begin
        w_issue_acc  = issue_valid & w_free_found;
        w_count_next = r_count + c_CNT_W'(w_issue_acc) - c_CNT_W'(w_rdy_found);
    end

    // ------------------------------------------------------------------
    // State update: flush, wakeup, dispatch and issue
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_busy      <= '0;
            r_has_dep_j <= '0;
            r_has_dep_k <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                r_type[i]   <= '0;
                r_op[i]     <= '0;
                r_val_j[i]  <= '0;
                r_val_k[i]  <= '0;
                r_dep_j[i]  <= '0;
                r_dep_k[i]  <= '0;
                r_rob_id[i] <= '0;
            end
            r_count    <= '0;
            rs_full    <= 1'b0;
            alu_en     <= 1'b0;
            alu_type   <= '0;
            alu_op     <= '0;
            alu_val_j  <= '0;
            alu_val_k  <= '0;
            alu_rob_id <= '0;
        end else if (!rdy_in) begin
            alu_en <= 1'b0;
        end else if (clear) begin
            r_busy  <= '0;
            r_count <= '0;
            rs_full <= 1'b0;
            alu_en  <= 1'b0;
        end else begin
            // Wakeup of waiting operands in busy entries.
            for (int i = 0; i < RS_SIZE; i++) begin
                if (r_busy[i] && r_has_dep_j[i] && w_snp_j[i][32]) begin
                    r_val_j[i]     <= w_snp_j[i][31:0];
                    r_has_dep_j[i] <= 1'b0;
                end
                if (r_busy[i] && r_has_dep_k[i] && w_snp_k[i][32]) begin
                    r_val_k[i]     <= w_snp_k[i][31:0];
                    r_has_dep_k[i] <= 1'b0;
                end
            end

            // Dispatch; alu_* data hold their last values when idle.
            alu_en <= w_rdy_found;
            if (w_rdy_found) begin
                alu_type            <= r_type[w_rdy_idx];
                alu_op              <= r_op[w_rdy_idx];
                alu_val_j           <= r_val_j[w_rdy_idx];
                alu_val_k           <= r_val_k[w_rdy_idx];
                alu_rob_id          <= r_rob_id[w_rdy_idx];
                r_busy[w_rdy_idx]   <= 1'b0;
            end

            // Issue into a slot that was free before this edge, so it never
            // collides with the slot being dispatched.
            if (w_issue_acc) begin
                r_busy[w_free_idx]      <= 1'b1;
                r_type[w_free_idx]      <= issue_type;
                r_op[w_free_idx]        <= issue_op;
                r_dep_j[w_free_idx]     <= issue_dep_j;
                r_dep_k[w_free_idx]     <= issue_dep_k;
                r_rob_id[w_free_idx]    <= issue_rob_id;
                if (issue_has_dep_j && w_iss_snp_j[32]) begin
                    r_val_j[w_free_idx]     <= w_iss_snp_j[31:0];
                    r_has_dep_j[w_free_idx] <= 1'b0;
                end else begin
                    r_val_j[w_free_idx]     <= issue_val_j;
                    r_has_dep_j[w_free_idx] <= issue_has_dep_j;
                end
                if (issue_has_dep_k && w_iss_snp_k[32]) begin
                    r_val_k[w_free_idx]     <= w_iss_snp_k[31:0];
                    r_has_dep_k[w_free_idx] <= 1'b0;
                end else begin
                    r_val_k[w_free_idx]     <= issue_val_k;
                    r_has_dep_k[w_free_idx] <= issue_has_dep_k;
                end
            end

            r_count <= w_count_next;
            rs_full <= (w_count_next >= c_FULL_MARK);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reservation_station.sv
`default_nettype none
// ============================================================================
// Module   : tb_reservation_station
// Summary  : Directed self-checking bench for reservation_station.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reservation_station;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        clear = 1'b0;
    logic        issue_valid = 1'b0;
    logic [2:0]  issue_type = '0;
    logic [7:0]  issue_op = '0;
    logic [31:0] issue_val_j = '0;
    logic [31:0] issue_val_k = '0;
    logic        issue_has_dep_j = 1'b0;
    logic        issue_has_dep_k = 1'b0;
    logic [3:0]  issue_dep_j = '0;
    logic [3:0]  issue_dep_k = '0;
    logic [3:0]  issue_rob_id = '0;
    logic        rs_full;
    logic        alu_cdb_valid = 1'b0;
    logic [3:0]  alu_cdb_rob_id = '0;
    logic [31:0] alu_cdb_val = '0;
    logic        lsb_cdb_valid = 1'b0;
    logic [3:0]  lsb_cdb_rob_id = '0;
    logic [31:0] lsb_cdb_val = '0;
    logic        alu_en;
    logic [2:0]  alu_type;
    logic [7:0]  alu_op;
    logic [31:0] alu_val_j;
    logic [31:0] alu_val_k;
    logic [3:0]  alu_rob_id;

    int n_checks = 0;
    int n_errors = 0;

    reservation_station #(.RS_SIZE(8), .ROB_WIDTH(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
        .issue_valid(issue_valid), .issue_type(issue_type), .issue_op(issue_op),
        .issue_val_j(issue_val_j), .issue_val_k(issue_val_k),
        .issue_has_dep_j(issue_has_dep_j), .issue_has_dep_k(issue_has_dep_k),
        .issue_dep_j(issue_dep_j), .issue_dep_k(issue_dep_k),
        .issue_rob_id(issue_rob_id), .rs_full(rs_full),
        .alu_cdb_valid(alu_cdb_valid), .alu_cdb_rob_id(alu_cdb_rob_id),
        .alu_cdb_val(alu_cdb_val),
        .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_rob_id(lsb_cdb_rob_id),
        .lsb_cdb_val(lsb_cdb_val),
        .alu_en(alu_en), .alu_type(alu_type), .alu_op(alu_op),
        .alu_val_j(alu_val_j), .alu_val_k(alu_val_k), .alu_rob_id(alu_rob_id)
    );

    always #5 clk_in = ~clk_in;

    // Advance one edge; inputs are then driven and outputs sampled 1 ns later.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        issue_valid   = 1'b0;
        alu_cdb_valid = 1'b0;
        lsb_cdb_valid = 1'b0;
        clear         = 1'b0;
    endtask

    // Drive one issue request; issuing while full would be a decoder error.
    task automatic issue(input logic [2:0] t, input logic [7:0] op,
                         input logic [31:0] vj, input logic [31:0] vk,
                         input logic hj, input logic hk,
                         input logic [3:0] dj, input logic [3:0] dk,
                         input logic [3:0] rob);
        n_checks++;
        if (rs_full !== 1'b0) begin
            n_errors++;
            $display("FAIL issue_protocol: rs_full=%b when issuing, required 0", rs_full);
        end
        issue_valid = 1'b1; issue_type = t; issue_op = op;
        issue_val_j = vj; issue_val_k = vk;
        issue_has_dep_j = hj; issue_has_dep_k = hk;
        issue_dep_j = dj; issue_dep_k = dk; issue_rob_id = rob;
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        repeat (2) tick();
        n_checks++;
        if (rs_full !== 1'b0) begin n_errors++; $display("FAIL reset_rs_full: got %b, required 0", rs_full); end
        n_checks++;
        if (alu_en !== 1'b0) begin n_errors++; $display("FAIL reset_alu_en: got %b, required 0", alu_en); end
        n_checks++;
        if ({alu_type, alu_op, alu_val_j, alu_val_k, alu_rob_id} !== 79'h0) begin
            n_errors++;
            $display("FAIL reset_alu_data: got j=%h k=%h rob=%h op=%h, required all 0",
                     alu_val_j, alu_val_k, alu_rob_id, alu_op);
        end
        rst_in = 1'b1;
        tick();
    endtask

    task automatic test_no_dep();
        issue(3'd1, 8'h01, 32'd5, 32'd7, 1'b0, 1'b0, 4'd0, 4'd0, 4'd3);
        tick(); idle();
        n_checks++;
        if (alu_en !== 1'b0) begin n_errors++; $display("FAIL nodep_early: alu_en=%b, required 0", alu_en); end
        tick();
        n_checks++;
        if ({alu_en, alu_type, alu_op, alu_val_j, alu_val_k, alu_rob_id} !== {1'b1, 3'd1, 8'h01, 32'd5, 32'd7, 4'd3}) begin
            n_errors++;
            $display("FAIL nodep_dispatch: en=%b type=%h op=%h j=%h k=%h rob=%h, required 1 1 01 5 7 3",
                     alu_en, alu_type, alu_op, alu_val_j, alu_val_k, alu_rob_id);
        end
        tick();
        n_checks++;
        if ({alu_en, alu_val_j} !== {1'b0, 32'd5}) begin
            n_errors++;
            $display("FAIL nodep_after: en=%b j=%h, required 0 and held 5", alu_en, alu_val_j);
        end
    endtask

    task automatic test_wakeup();
        issue(3'd2, 8'h10, 32'd0, 32'd3, 1'b1, 1'b0, 4'd2, 4'd0, 4'd5);
        tick(); idle();
        for (int c = 0; c < 2; c++) begin
            tick();
            n_checks++;
            if (alu_en !== 1'b0) begin n_errors++; $display("FAIL wakeup_wait: alu_en=%b, required 0", alu_en); end
        end
        alu_cdb_valid = 1'b1; alu_cdb_rob_id = 4'd2; alu_cdb_val = 32'hAB;
        tick(); idle();
        n_checks++;
        if (alu_en !== 1'b0) begin n_errors++; $display("FAIL wakeup_same_cycle: alu_en=%b, required 0", alu_en); end
        tick();
        n_checks++;
        if ({alu_en, alu_val_j, alu_val_k, alu_rob_id} !== {1'b1, 32'hAB, 32'd3, 4'd5}) begin
            n_errors++;
            $display("FAIL wakeup_dispatch: en=%b j=%h k=%h rob=%h, required 1 ab 3 5",
                     alu_en, alu_val_j, alu_val_k, alu_rob_id);
        end
        tick();
    endtask

    task automatic test_bypass();
        issue(3'd3, 8'h20, 32'd11, 32'd0, 1'b0, 1'b1, 4'd0, 4'd4, 4'd6);
        lsb_cdb_valid = 1'b1; lsb_cdb_rob_id = 4'd4; lsb_cdb_val = 32'd9;
        tick(); idle();
        n_checks++;
        if (alu_en !== 1'b0) begin n_errors++; $display("FAIL bypass_early: alu_en=%b, required 0", alu_en); end
        tick();
        n_checks++;
        if ({alu_en, alu_val_j, alu_val_k, alu_rob_id} !== {1'b1, 32'd11, 32'd9, 4'd6}) begin
            n_errors++;
            $display("FAIL bypass_dispatch: en=%b j=%h k=%h rob=%h, required 1 b 9 6",
                     alu_en, alu_val_j, alu_val_k, alu_rob_id);
        end
        tick();
    endtask

    task automatic test_cdb_priority();
        issue(3'd1, 8'h02, 32'd0, 32'd1, 1'b1, 1'b0, 4'd7, 4'd0, 4'd9);
        tick(); idle();
        alu_cdb_valid = 1'b1; alu_cdb_rob_id = 4'd7; alu_cdb_val = 32'h111;
        lsb_cdb_valid = 1'b1; lsb_cdb_rob_id = 4'd7; lsb_cdb_val = 32'h222;
        tick(); idle();
        tick();
        n_checks++;
        if ({alu_en, alu_val_j, alu_rob_id} !== {1'b1, 32'h111, 4'd9}) begin
            n_errors++;
            $display("FAIL cdb_priority: en=%b j=%h rob=%h, required 1 111 9", alu_en, alu_val_j, alu_rob_id);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        issue(3'd1, 8'h03, 32'd1, 32'd0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd1);
        tick();
        n_checks++;
        if (alu_en !== 1'b0) begin n_errors++; $display("FAIL b2b_first: alu_en=%b, required 0", alu_en); end
        issue(3'd1, 8'h03, 32'd2, 32'd0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd2);
        tick();
        n_checks++;
        if ({alu_en, alu_rob_id} !== {1'b1, 4'd1}) begin n_errors++; $display("FAIL b2b_a: en=%b rob=%h, required 1 1", alu_en, alu_rob_id); end
        issue(3'd1, 8'h03, 32'd3, 32'd0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd3);
        tick(); idle();
        n_checks++;
        if ({alu_en, alu_rob_id} !== {1'b1, 4'd2}) begin n_errors++; $display("FAIL b2b_b: en=%b rob=%h, required 1 2", alu_en, alu_rob_id); end
        tick();
        n_checks++;
        if ({alu_en, alu_rob_id, alu_val_j} !== {1'b1, 4'd3, 32'd3}) begin
            n_errors++;
            $display("FAIL b2b_c: en=%b rob=%h j=%h, required 1 3 3", alu_en, alu_rob_id, alu_val_j);
        end
        tick();
        n_checks++;
        if ({alu_en, rs_full} !== 2'b00) begin n_errors++; $display("FAIL b2b_end: en=%b full=%b, required 0 0", alu_en, rs_full); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 7; i++) begin
            issue(3'd1, 8'h04, 32'd0, 32'(i), 1'b1, 1'b0, 4'(i + 1), 4'd0, 4'(8 + i));
            tick(); idle();
            n_checks++;
            if (rs_full !== (i == 6)) begin
                n_errors++;
                $display("FAIL full_fill%0d: rs_full=%b, required %b", i, rs_full, (i == 6));
            end
        end
        alu_cdb_valid = 1'b1; alu_cdb_rob_id = 4'd3; alu_cdb_val = 32'h33;
        tick(); idle();
        n_checks++;
        if ({alu_en, rs_full} !== 2'b01) begin n_errors++; $display("FAIL full_wake: en=%b full=%b, required 0 1", alu_en, rs_full); end
        tick();
        n_checks++;
        if ({alu_en, alu_rob_id, alu_val_j, alu_val_k, rs_full} !== {1'b1, 4'd10, 32'h33, 32'd2, 1'b0}) begin
            n_errors++;
            $display("FAIL full_drain: en=%b rob=%h j=%h k=%h full=%b, required 1 a 33 2 0",
                     alu_en, alu_rob_id, alu_val_j, alu_val_k, rs_full);
        end
        clear = 1'b1;
        tick(); idle();
    endtask

    task automatic test_clear();
        for (int i = 0; i < 5; i++) begin
            issue(3'd2, 8'h05, 32'd0, 32'd0, 1'b1, 1'b0, 4'(i + 1), 4'd0, 4'(i));
            tick(); idle();
        end
        n_checks++;
        if (rs_full !== 1'b0) begin n_errors++; $display("FAIL clear_five: rs_full=%b, required 0", rs_full); end
        issue(3'd1, 8'h06, 32'h77, 32'd0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd7);
        clear = 1'b1;
        tick(); idle();
        n_checks++;
        if ({alu_en, rs_full} !== 2'b00) begin n_errors++; $display("FAIL clear_edge: en=%b full=%b, required 0 0", alu_en, rs_full); end
        for (int t = 1; t <= 5; t++) begin
            alu_cdb_valid = 1'b1; alu_cdb_rob_id = 4'(t); alu_cdb_val = 32'(t);
            tick(); idle();
            n_checks++;
            if (alu_en !== 1'b0) begin n_errors++; $display("FAIL clear_flushed_tag%0d: alu_en=%b, required 0", t, alu_en); end
        end
        tick();
        n_checks++;
        if (alu_en !== 1'b0) begin n_errors++; $display("FAIL clear_tail: alu_en=%b, required 0", alu_en); end
    endtask

    task automatic test_rdy_hold();
        issue(3'd1, 8'h07, 32'd0, 32'h00, 1'b1, 1'b0, 4'd9,  4'd0, 4'd1);
        tick();
        issue(3'd1, 8'h07, 32'd0, 32'h10, 1'b1, 1'b0, 4'd11, 4'd0, 4'd2);
        tick();
        issue(3'd1, 8'h07, 32'd0, 32'h00, 1'b1, 1'b0, 4'd10, 4'd0, 4'd3);
        tick();
        issue(3'd1, 8'h07, 32'd0, 32'h30, 1'b1, 1'b0, 4'd11, 4'd0, 4'd4);
        tick(); idle();
        alu_cdb_valid = 1'b1; alu_cdb_rob_id = 4'd11; alu_cdb_val = 32'h55;
        tick(); idle();
        rdy_in = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_checks++;
            if (alu_en !== 1'b0) begin n_errors++; $display("FAIL rdy_low%0d: alu_en=%b, required 0", c, alu_en); end
        end
        rdy_in = 1'b1;
        tick();
        n_checks++;
        if ({alu_en, alu_rob_id, alu_val_j, alu_val_k} !== {1'b1, 4'd2, 32'h55, 32'h10}) begin
            n_errors++;
            $display("FAIL rdy_first: en=%b rob=%h j=%h k=%h, required 1 2 55 10", alu_en, alu_rob_id, alu_val_j, alu_val_k);
        end
        tick();
        n_checks++;
        if ({alu_en, alu_rob_id, alu_val_j, alu_val_k} !== {1'b1, 4'd4, 32'h55, 32'h30}) begin
            n_errors++;
            $display("FAIL rdy_second: en=%b rob=%h j=%h k=%h, required 1 4 55 30", alu_en, alu_rob_id, alu_val_j, alu_val_k);
        end
        tick();
        n_checks++;
        if (alu_en !== 1'b0) begin n_errors++; $display("FAIL rdy_after: alu_en=%b, required 0", alu_en); end
        clear = 1'b1;
        tick(); idle();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 7; i++) begin
            issue(3'd1, 8'h08, 32'd0, 32'd0, 1'b1, 1'b0, 4'(i + 1), 4'd0, 4'(i));
            tick(); idle();
        end
        n_checks++;
        if (rs_full !== 1'b1) begin n_errors++; $display("FAIL areset_pre_full: rs_full=%b, required 1", rs_full); end
        #2 rst_in = 1'b0;
        #1;
        n_checks++;
        if ({rs_full, alu_en, alu_val_j, alu_rob_id} !== {1'b0, 1'b0, 32'd0, 4'd0}) begin
            n_errors++;
            $display("FAIL areset_immediate: full=%b en=%b j=%h rob=%h, required 0 0 0 0",
                     rs_full, alu_en, alu_val_j, alu_rob_id);
        end
        #1 rst_in = 1'b1;
        tick();
        for (int t = 1; t <= 7; t++) begin
            alu_cdb_valid = 1'b1; alu_cdb_rob_id = 4'(t); alu_cdb_val = 32'(t);
            tick(); idle();
            n_checks++;
            if (alu_en !== 1'b0) begin n_errors++; $display("FAIL areset_tag%0d: alu_en=%b, required 0", t, alu_en); end
        end
        tick();
        n_checks++;
        if (alu_en !== 1'b0) begin n_errors++; $display("FAIL areset_tail: alu_en=%b, required 0", alu_en); end
    endtask

    initial begin
        test_reset();
        test_no_dep();
        test_wakeup();
        test_bypass();
        test_cdb_priority();
        test_back_to_back();
        test_full();
        test_clear();
        test_rdy_hold();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
